// File: rtl/sel_wss_mod.sv
// Working-set selection: one sequential pass over label/alpha/gradient RAMs
// finds the maximal violating pair (i_up, i_low), the optimality gap and a converged flag.
module sel_wss_mod #(
   parameter int AW = 11,
   parameter int DW = 64
) (
   input  logic          clk,
   input  logic          rst_,
   input  logic          start,
   input  logic [AW-1:0] n_vector,
   input  logic [DW-1:0] c_bound,
   input  logic [DW-1:0] eps,
   output logic [AW-1:0] ram_rd_addr,
   input  logic          ram_label_q,
   input  logic [DW-1:0] ram_a_q,
   input  logic [DW-1:0] ram_a_grad_q,
   output logic [AW-1:0] i_up,
   output logic [AW-1:0] i_low,
   output logic [DW-1:0] m_val,
   output logic [DW-1:0] M_val,
   output logic          converged,
   output logic          finish
);

   typedef enum logic [2:0] {IDLE, READ, DRAIN, CMP, DONE} state_t;

   localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
   localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};

   state_t state, state_nx;

   logic [AW-1:0]        addr, idx_d, up_idx, low_idx;
   logic                 vld_d, up_found, low_found, last;
   logic signed [DW-1:0] run_max, run_min, v, a_s, c_s;
   logic                 a_pos, a_lt_c, in_up, in_low, upd_up, upd_low;
   logic signed [DW:0]   gap, eps_x;

   assign ram_rd_addr = addr;
   assign finish      = (state == DONE);
   assign last        = (addr == n_vector - 1'b1);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = (n_vector == '0) ? DONE : READ;
         READ:    if (last) state_nx = DRAIN;
         DRAIN:   state_nx = CMP;
         CMP:     state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Returning sample evaluation; vld_d/idx_d tag the RAM output with its address.
   always_comb begin
      a_s    = $signed(ram_a_q);
      c_s    = $signed(c_bound);
      a_pos  = !a_s[DW-1] && (|a_s);
      a_lt_c = (a_s < c_s);
      if (ram_label_q)
         v = (ram_a_grad_q == SMIN) ? $signed(SMAX) : -$signed(ram_a_grad_q);
      else
         v = $signed(ram_a_grad_q);
      in_up   = ram_label_q ? a_lt_c : a_pos;
      in_low  = ram_label_q ? a_pos  : a_lt_c;
      upd_up  = vld_d && in_up  && (!up_found  || (v > run_max));
      upd_low = vld_d && in_low && (!low_found || (v < run_min));
      gap     = $signed({run_max[DW-1], run_max}) - $signed({run_min[DW-1], run_min});
      eps_x   = $signed({eps[DW-1], eps});
   end

   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         state     <= IDLE;
         addr      <= '0;
         idx_d     <= '0;
         vld_d     <= 1'b0;
         run_max   <= '0;
         run_min   <= '0;
         up_idx    <= '0;
         low_idx   <= '0;
         up_found  <= 1'b0;
         low_found <= 1'b0;
         i_up      <= '0;
         i_low     <= '0;
         m_val     <= '0;
         M_val     <= '0;
         converged <= 1'b0;
      end else begin
         state <= state_nx;
         vld_d <= (state == READ);
         idx_d <= addr;
         case (state)
            IDLE: if (start) begin
               addr      <= '0;
               run_max   <= SMIN;
               run_min   <= SMAX;
               up_found  <= 1'b0;
               low_found <= 1'b0;
               if (n_vector == '0) begin
                  i_up      <= '0;
                  i_low     <= '0;
                  m_val     <= '0;
                  M_val     <= '0;
                  converged <= 1'b1;
               end
            end
            READ: if (!last) addr <= addr + 1'b1;
            CMP: begin
               i_up      <= up_found  ? up_idx  : '0;
               i_low     <= low_found ? low_idx : '0;
               m_val     <= up_found  ? run_max : '0;
               M_val     <= low_found ? run_min : '0;
               converged <= !up_found || !low_found || (gap < eps_x);
            end
            default: ;
         endcase
         // vld_d is never set in IDLE, so these cannot collide with the pass init
         if (upd_up) begin
            run_max  <= v;
            up_idx   <= idx_d;
            up_found <= 1'b1;
         end
         if (upd_low) begin
            run_min   <= v;
            low_idx   <= idx_d;
            low_found <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sel_wss_mod.sv
// Scoreboard bench for sel_wss_mod: stimulus pushes expected results, a monitor
// pops and checks them whenever finish pulses.
module tb_sel_wss_mod;

   localparam int AW = 11;
   localparam longint ONE  = 64'sh0000_0001_0000_0000;
   localparam longint MINV = 64'sh8000_0000_0000_0000;
   localparam longint MAXV = 64'sh7FFF_FFFF_FFFF_FFFF;

   typedef struct {
      logic [AW-1:0] iu;
      logic [AW-1:0] il;
      logic [63:0]   mv;
      logic [63:0]   lv;
      logic          conv;
      int            cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_ = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] n_vector = '0;
   logic [63:0]   c_bound = '0;
   logic [63:0]   eps = '0;
   logic [AW-1:0] ram_rd_addr;
   logic          ram_label_q = 1'b0;
   logic [63:0]   ram_a_q = '0;
   logic [63:0]   ram_a_grad_q = '0;
   logic [AW-1:0] i_up, i_low;
   logic [63:0]   m_val, M_val;
   logic          converged, finish;

   bit     lab [2048];
   longint aa  [2048];
   longint gg  [2048];

   exp_t   sb[$];
   exp_t   mon_ex;
   int     cyc = 0;
   int     n_cmp = 0;
   int     n_bad = 0;

   sel_wss_mod #(.AW(AW), .DW(64)) dut (
      .clk(clk), .rst_(rst_), .start(start), .n_vector(n_vector),
      .c_bound(c_bound), .eps(eps), .ram_rd_addr(ram_rd_addr),
      .ram_label_q(ram_label_q), .ram_a_q(ram_a_q), .ram_a_grad_q(ram_a_grad_q),
      .i_up(i_up), .i_low(i_low), .m_val(m_val), .M_val(M_val),
      .converged(converged), .finish(finish)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc          <= cyc + 1;
      ram_label_q  <= lab[ram_rd_addr];
      ram_a_q      <= aa[ram_rd_addr];
      ram_a_grad_q <= gg[ram_rd_addr];
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_ && finish) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_finish: got finish at cycle %0d expected none", cyc);
         end else begin
            mon_ex = sb.pop_front();
            chk("finish_cycle", 64'(cyc), 64'(mon_ex.cyc));
            chk("i_up", 64'(i_up), 64'(mon_ex.iu));
            chk("i_low", 64'(i_low), 64'(mon_ex.il));
            chk("m_val", m_val, mon_ex.mv);
            chk("M_val", M_val, mon_ex.lv);
            chk("converged", 64'(converged), 64'(mon_ex.conv));
         end
      end
   end

   // Reference: direct evaluation of the set definitions over the whole vector.
   function automatic exp_t model(input int n, input longint c, input longint e);
      exp_t r;
      bit uf = 0, lf = 0, up, low;
      longint mx = 0, mn = 0, v;
      int ui = 0, li = 0;
      logic signed [64:0] g;
      for (int i = 0; i < n; i++) begin
         if (lab[i]) v = (gg[i] == MINV) ? MAXV : -gg[i];
         else        v = gg[i];
         up  = lab[i] ? (aa[i] < c) : (aa[i] > 0);
         low = lab[i] ? (aa[i] > 0) : (aa[i] < c);
         if (up && (!uf || v > mx)) begin mx = v; ui = i; uf = 1; end
         if (low && (!lf || v < mn)) begin mn = v; li = i; lf = 1; end
      end
      r.iu = uf ? AW'(ui) : '0;
      r.il = lf ? AW'(li) : '0;
      r.mv = uf ? mx : 64'd0;
      r.lv = lf ? mn : 64'd0;
      g = mx;
      g = g - mn;
      r.conv = !uf || !lf || (g < e);
      r.cyc = 0;
      return r;
   endfunction

   task automatic run_pass(input exp_t ex, input bit spur);
      int n, k;
      n = int'(n_vector);
      @(posedge clk); #1;
      ex.cyc = cyc + 1 + ((n == 0) ? 0 : n + 2);
      sb.push_back(ex);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (spur && n > 0) begin
         k = $urandom_range(0, n);
         repeat (k) @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      for (int i = 0; i < n + 10 && cyc < ex.cyc + 2; i++) @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_addr"}, 64'(ram_rd_addr), 64'd0);
      chk({tag, "_i_up"}, 64'(i_up), 64'd0);
      chk({tag, "_i_low"}, 64'(i_low), 64'd0);
      chk({tag, "_m_val"}, m_val, 64'd0);
      chk({tag, "_M_val"}, M_val, 64'd0);
      chk({tag, "_conv"}, 64'(converged), 64'd0);
      chk({tag, "_finish"}, 64'(finish), 64'd0);
   endtask

   function automatic exp_t mk(input int iu, input int il, input longint mv,
                               input longint lv, input bit conv);
      exp_t r;
      r.iu = AW'(iu); r.il = AW'(il); r.mv = mv; r.lv = lv; r.conv = conv; r.cyc = 0;
      return r;
   endfunction

   task automatic set_vec(input int i, input bit y, input longint a, input longint g);
      lab[i] = y; aa[i] = a; gg[i] = g;
   endtask

   task automatic rand_fill(input int n, input longint c);
      longint a, g;
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 4))
            0: a = 0;
            1: a = c;
            2: a = c / 2;
            3: a = -ONE;
            default: a = c + 1;
         endcase
         case ($urandom_range(0, 5))
            4: g = longint'({$urandom(), $urandom()});
            5: g = MINV;
            default: g = (longint'($urandom_range(0, 8)) - 4) <<< 30;
         endcase
         set_vec(i, 1'($urandom_range(0, 1)), a, g);
      end
   endtask

   initial begin
      exp_t ex;
      longint c, e;
      int n;

      repeat (3) @(posedge clk);
      #1;
      check_reset("por");
      rst_ = 1'b0;

      // Worked example: gap 1.5
      n_vector = 4; c_bound = ONE; eps = 64'd4294967;
      set_vec(0, 1, 0,       -ONE);
      set_vec(1, 0, ONE / 2, -ONE / 2);
      set_vec(2, 1, ONE,     -2 * ONE);
      set_vec(3, 0, 0,       ONE / 4);
      run_pass(mk(0, 1, ONE, 64'hFFFF_FFFF_8000_0000, 1'b0), 1'b0);
      eps = 2 * ONE;
      run_pass(mk(0, 1, ONE, 64'hFFFF_FFFF_8000_0000, 1'b1), 1'b0);

      // Ties resolve to the lowest index
      n_vector = 3; eps = 64'd1;
      for (int i = 0; i < 3; i++) set_vec(i, 1, ONE / 2, 0);
      run_pass(mk(0, 0, 0, 0, 1'b1), 1'b0);

      // Empty I_low
      n_vector = 2;
      set_vec(0, 1, 0, ONE);
      set_vec(1, 1, 0, -3 * ONE);
      run_pass(mk(1, 0, 3 * ONE, 0, 1'b1), 1'b0);

      n_vector = 0;
      run_pass(mk(0, 0, 0, 0, 1'b1), 1'b0);

      // Saturated negation, then the same pass again with a stray start mid-pass
      n_vector = 1; c_bound = ONE; eps = 0;
      set_vec(0, 1, 0, MINV);
      run_pass(mk(0, 0, MAXV, 0, 1'b1), 1'b0);
      run_pass(mk(0, 0, MAXV, 0, 1'b1), 1'b1);

      // Reset in the middle of a long pass
      n_vector = 100; c_bound = ONE; eps = ONE;
      rand_fill(100, ONE);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (20) @(posedge clk);
      #1 rst_ = 1'b1;
      @(negedge clk);
      check_reset("midrst");
      @(posedge clk); #1 rst_ = 1'b0;
      run_pass(model(100, ONE, ONE), 1'b0);

      // Randomized passes against the reference
      for (int t = 0; t < 30; t++) begin
         n = $urandom_range(1, 40);
         c = ($urandom_range(0, 1) == 0) ? ONE
             : (longint'($urandom_range(1, 32'h7FFF_FFFF)) << $urandom_range(0, 30));
         case ($urandom_range(0, 3))
            0: e = 0;
            1: e = 1;
            2: e = ONE;
            default: e = longint'({1'b0, 31'($urandom()), $urandom()});
         endcase
         rand_fill(n, c);
         n_vector = AW'(n); c_bound = c; eps = e;
         ex = model(n, c, e);
         run_pass(ex, 1'($urandom_range(0, 1)));
      end

      repeat (5) @(posedge clk);
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL missing_finish: got %0d results pending expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sel_wss_mod.md
Name: sel_wss_mod

Overview:
- Working-set selection stage of the SMO training loop. It sits directly downstream of the alpha-gradient stage and consumes the gradient RAM that stage fills.
- Makes one sequential pass over the label, alpha and gradient RAMs and finds the maximal violating pair (i_up, i_low).
- Reports the optimality gap and a converged flag to the top-level training controller.
- All 64-bit values are signed two's-complement Q32.32 fixed point.

Parameters:
- AW, 11, vector index / RAM address width
- DW, 64, data width of alpha, gradient, C and eps

Ports:
- clk  input  1  system clock, rising edge
- rst_  input  1  reset, asynchronous, active-high (port name kept per codebase; asserted = 1)
- start  input  1  single-cycle request to begin a pass; sampled in IDLE only
- n_vector  input  AW  number of training vectors; indices 0..n_vector-1
- c_bound  input  DW  box constraint C, positive
- eps  input  DW  stopping tolerance, non-negative
- ram_rd_addr  output  AW  shared read address to label, alpha and gradient RAMs
- ram_label_q  input  1  label of addressed vector: 1 = +1, 0 = -1
- ram_a_q  input  DW  alpha of addressed vector
- ram_a_grad_q  input  DW  gradient of addressed vector
- i_up  output  AW  index of maximum over I_up
- i_low  output  AW  index of minimum over I_low
- m_val  output  DW  max over I_up of -y*grad
- M_val  output  DW  min over I_low of -y*grad
- converged  output  1  1 when m_val - M_val < eps, or when either set is empty
- finish  output  1  one-cycle pulse; result outputs are valid from this cycle on

Behaviour:
- Reset (rst_=1, any time, including mid-pass): state IDLE; ram_rd_addr=0; i_up=0, i_low=0, m_val=0, M_val=0, converged=0, finish=0; running registers cleared.
- RAM model: synchronous read, 1-cycle latency. The q for address k is valid in the cycle after ram_rd_addr=k.
- FSM states: IDLE, READ, DRAIN, CMP, DONE.
- IDLE:
  - start=1 and n_vector=0 -> DONE with converged=1, m_val=0, M_val=0, i_up=0, i_low=0.
  - start=1 and n_vector>0 -> READ. ram_rd_addr=0; run_max=0x8000_0000_0000_0000; run_min=0x7FFF_FFFF_FFFF_FFFF; up_found=0; low_found=0.
- READ: ram_rd_addr increments by 1 each cycle. When ram_rd_addr=n_vector-1 -> DRAIN. ram_rd_addr never exceeds n_vector-1; it holds its value in later states.
- A one-cycle delayed valid/index pipeline tags each returning sample with its address. Samples are evaluated in READ (from the second cycle on) and in DRAIN.
- Per sample:
  - v = -grad, or +grad when y=-1. Negating 0x8000_0000_0000_0000 saturates to 0x7FFF_FFFF_FFFF_FFFF.
  - in_up = (y=+1 and a<C) or (y=-1 and a>0).
  - in_low = (y=+1 and a>0) or (y=-1 and a<C).
  - Comparisons are signed.
  - in_up and (v>run_max or !up_found) -> update run_max and up_idx; set up_found.
  - in_low and (v<run_min or !low_found) -> update run_min and low_idx; set low_found.
  - Ties: strict comparison, so the lowest index wins.
- DRAIN: evaluates the final sample, then -> CMP.
- CMP:
  - gap = run_max - run_min computed at 65 bits, no overflow.
  - converged = !up_found | !low_found | (gap < eps).
  - Latch i_up, i_low, m_val, M_val. When a set is empty, its index/value output is 0.
  - -> DONE.
- DONE: finish=1 for exactly one cycle, then -> IDLE. Result outputs hold until the next pass reaches CMP.
- Latency: finish is high in the cycle after the (n_vector+2)-th rising edge following the edge that samples start. For n_vector=0, finish follows the next edge.
- start while not in IDLE is ignored. start coinciding with finish (DONE) is ignored.
- n_vector or c_bound changing mid-pass is unsupported. The controller holds both stable from start to finish.

Test Plan:
- Reset mid-pass: assert rst_ during READ with n_vector=100 -> all outputs 0 next cycle, IDLE; new start runs a clean pass.
- n_vector=4, C=1.0; y={+1,-1,+1,-1}; a={0,0.5,1.0,0}; grad={-1.0,-0.5,-2.0,0.25}:
  - I_up={0,1}, v={1.0,-0.5} -> i_up=0, m_val=0x0000_0001_0000_0000.
  - I_low={1,2,3}, v={-0.5,2.0,0.25} -> i_low=1, M_val=0xFFFF_FFFF_8000_0000.
  - gap 1.5, eps=0.001 -> converged=0.
  - finish 6 edges after start.
- Same data with eps=2.0 -> converged=1; indices unchanged.
- Ties: n_vector=3, all y=+1, a=0.5, C=1, grad all 0 -> i_up=0, i_low=0, m_val=M_val=0, converged=1 for eps=1 LSB.
- Empty set: n_vector=2, y=+1, a=0 for both -> I_low empty -> converged=1, i_low=0, M_val=0. n_vector=0 -> finish on the next edge, converged=1.
- Saturation and back-to-back passes: grad=0x8000_0000_0000_0000, y=+1, a=0 -> v=0x7FFF_FFFF_FFFF_FFFF selected as m_val. start pulsed during READ has no effect; second start after finish gives identical results.
